// File: rtl/sf_pkg.sv
// Shared types for the HN-F snoop filter: request opcodes, coarse line states
// and address-slicing helpers.
package sf_pkg;

  localparam int CHI_CACHE_STATE_W = 2;
  localparam int ADDR_MAX_W        = 64;

  typedef enum logic [1:0] {
    LOOKUP       = 2'd0,
    ALLOC_SHARED = 2'd1,
    ALLOC_UNIQUE = 2'd2,
    EVICT        = 2'd3
  } sf_op_e;

  localparam logic [CHI_CACHE_STATE_W-1:0] SF_I = 2'd0;
  localparam logic [CHI_CACHE_STATE_W-1:0] SF_U = 2'd1;
  localparam logic [CHI_CACHE_STATE_W-1:0] SF_S = 2'd2;

  // Right-aligns the field starting at lsb; the caller truncates to its width.
  function automatic logic [ADDR_MAX_W-1:0] addr_field(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int lsb);
    return addr >> lsb;
  endfunction

  function automatic logic is_alloc(input sf_op_e op);
    return (op == ALLOC_SHARED) || (op == ALLOC_UNIQUE);
  endfunction

endpackage

// File: rtl/sf_assoc_if.sv
// Request, response and back-invalidation signals of the snoop filter.
// The master side is the HN-F request flow, the slave side is sf_assoc.
interface sf_assoc_if #(
  parameter int ADDR_W = 48,
  parameter int NUM_RN = 4
) ();
  import sf_pkg::*;

  localparam int SRC_W = $clog2(NUM_RN);

  logic                         req_valid;
  logic                         req_ready;
  logic [ADDR_W-1:0]            req_addr;
  sf_op_e                       req_op;
  logic [SRC_W-1:0]             req_src;

  logic                         rsp_valid;
  logic                         rsp_hit;
  logic [CHI_CACHE_STATE_W-1:0] rsp_state;
  logic [NUM_RN-1:0]            rsp_vec;

  logic                         binv_valid;
  logic                         binv_ready;
  logic [ADDR_W-1:0]            binv_addr;
  logic [NUM_RN-1:0]            binv_vec;

  modport master (
    output req_valid, req_addr, req_op, req_src, binv_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_state, rsp_vec,
           binv_valid, binv_addr, binv_vec
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_src, binv_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_state, rsp_vec,
           binv_valid, binv_addr, binv_vec
  );

endinterface

// File: rtl/sf_victim_sel.sv
// Replacement choice for one set: lowest-index invalid way, otherwise the
// round-robin pointer, in which case a tracked line must be evicted.
module sf_victim_sel #(
  parameter int WAYS  = 4,
  parameter int PTR_W = 2
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] way_idx,
  output logic             need_evict
);

  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    need_evict = &valid;
    way_idx    = ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) way_idx = PTR_W'(w);
    end
  end

endmodule

// File: rtl/sf_assoc.sv
// Set-associative snoop filter: two-stage pipeline (accept, then read/compare/
// write), per-line presence vector and state, back-invalidation on eviction.
module sf_assoc
  import sf_pkg::*;
#(
  parameter int ADDR_W   = 48,
  parameter int OFFSET_W = 6,
  parameter int SET_W    = 7,
  parameter int WAYS     = 4,
  parameter int NUM_RN   = 4
) (
  input  logic      clock,
  input  logic      reset,
  sf_assoc_if.slave bus
);

  localparam int SET_NUM = 1 << SET_W;
  localparam int SRC_W   = $clog2(NUM_RN);
  localparam int TAG_W   = ADDR_W - OFFSET_W - SET_W;
  localparam int PTR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [CHI_CACHE_STATE_W-1:0] state_t;

  // Flop-based arrays
  logic [WAYS-1:0]   valid_q [SET_NUM];
  logic [PTR_W-1:0]  ptr_q   [SET_NUM];
  logic [TAG_W-1:0]  tag_q   [SET_NUM][WAYS];
  state_t            state_q [SET_NUM][WAYS];
  logic [NUM_RN-1:0] vec_q   [SET_NUM][WAYS];

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
  sf_op_e            s1_op_q,    s1_op_d;
  logic [SRC_W-1:0]  s1_src_q,   s1_src_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q,   rsp_hit_d;
  state_t            rsp_state_q, rsp_state_d;
  logic [NUM_RN-1:0] rsp_vec_q,   rsp_vec_d;

  logic              binv_valid_q, binv_valid_d;
  logic [ADDR_W-1:0] binv_addr_q,  binv_addr_d;
  logic [NUM_RN-1:0] binv_vec_q,   binv_vec_d;

  logic [SET_W-1:0]  s1_set;
  logic [TAG_W-1:0]  s1_tag;
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [PTR_W-1:0]  hit_way, victim_way, wr_way, ptr_next;
  logic              need_evict, alloc_miss, binv_load, s1_done, req_ready;
  logic              wr_en, wr_valid, ptr_adv;
  logic [NUM_RN-1:0] src_oh, old_vec, wr_vec;
  state_t            old_state, wr_state;

  assign s1_set = SET_W'(addr_field(ADDR_MAX_W'(s1_addr_q), OFFSET_W));
  assign s1_tag = TAG_W'(addr_field(ADDR_MAX_W'(s1_addr_q), OFFSET_W + SET_W));

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[s1_set][w] && (tag_q[s1_set][w] == s1_tag);
      if (hit_vec[w]) hit_way = PTR_W'(w);
    end
  end
  assign hit = |hit_vec;

  sf_victim_sel #(.WAYS(WAYS), .PTR_W(PTR_W)) u_victim_sel (
    .valid      (valid_q[s1_set]),
    .ptr        (ptr_q[s1_set]),
    .way_idx    (victim_way),
    .need_evict (need_evict)
  );

  // S1 may only retire an eviction if the binv slot is free or draining now.
  always_comb begin
    alloc_miss = s1_valid_q && !hit && is_alloc(s1_op_q);
    binv_load  = alloc_miss && need_evict;
    s1_done    = s1_valid_q && (!binv_load || !binv_valid_q || bus.binv_ready);
    req_ready  = reset && (!s1_valid_q || s1_done);
    src_oh     = NUM_RN'(1) << s1_src_q;
    old_state  = hit ? state_q[s1_set][hit_way] : SF_I;
    old_vec    = hit ? vec_q[s1_set][hit_way] : '0;
    wr_way     = hit ? hit_way : victim_way;
    ptr_next   = (ptr_q[s1_set] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[s1_set] + 1'b1;

    wr_en    = 1'b0;
    wr_valid = 1'b1;
    wr_vec   = old_vec;
    wr_state = old_state;
    case (s1_op_q)
      ALLOC_SHARED: begin
        wr_en    = 1'b1;
        wr_vec   = old_vec | src_oh;
        wr_state = ($countones(wr_vec) == 1) ? SF_U : SF_S;
      end
      ALLOC_UNIQUE: begin
        wr_en    = 1'b1;
        wr_vec   = src_oh;
        wr_state = SF_U;
      end
      EVICT: begin
        wr_en  = hit;
        wr_vec = old_vec & ~src_oh;
        if (wr_vec == '0) begin
          wr_valid = 1'b0;
          wr_state = SF_I;
        end
      end
      default: ;
    endcase
    wr_en   = wr_en && s1_done;
    ptr_adv = binv_load && s1_done;
  end

  always_comb begin
    s1_valid_d = s1_valid_q && !s1_done;
    s1_addr_d  = s1_addr_q;
    s1_op_d    = s1_op_q;
    s1_src_d   = s1_src_q;
    if (bus.req_valid && req_ready) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = bus.req_addr;
      s1_op_d    = bus.req_op;
      s1_src_d   = bus.req_src;
    end

    rsp_valid_d = s1_done;
    rsp_hit_d   = rsp_hit_q;
    rsp_state_d = rsp_state_q;
    rsp_vec_d   = rsp_vec_q;
    if (s1_done) begin
      rsp_hit_d   = hit;
      rsp_state_d = old_state;
      rsp_vec_d   = old_vec;
    end

    binv_valid_d = binv_valid_q && !bus.binv_ready;
    binv_addr_d  = binv_addr_q;
    binv_vec_d   = binv_vec_q;
    if (binv_load && s1_done) begin
      binv_valid_d = 1'b1;
      binv_addr_d  = {tag_q[s1_set][victim_way], s1_set, {OFFSET_W{1'b0}}};
      binv_vec_d   = vec_q[s1_set][victim_way];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_op_q      <= LOOKUP;
      s1_src_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_state_q  <= SF_I;
      rsp_vec_q    <= '0;
      binv_valid_q <= 1'b0;
      binv_addr_q  <= '0;
      binv_vec_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_op_q      <= s1_op_d;
      s1_src_q     <= s1_src_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_state_q  <= rsp_state_d;
      rsp_vec_q    <= rsp_vec_d;
      binv_valid_q <= binv_valid_d;
      binv_addr_q  <= binv_addr_d;
      binv_vec_q   <= binv_vec_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (wr_en)   valid_q[s1_set][wr_way] <= wr_valid;
      if (ptr_adv) ptr_q[s1_set]           <= ptr_next;
    end
  end

  // NOTE: line payload is not reset; valid_q alone decides whether it means anything.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[s1_set][wr_way]   <= s1_tag;
      state_q[s1_set][wr_way] <= wr_state;
      vec_q[s1_set][wr_way]   <= wr_vec;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_state  = rsp_state_q;
  assign bus.rsp_vec    = rsp_vec_q;
  assign bus.binv_valid = binv_valid_q;
  assign bus.binv_addr  = binv_addr_q;
  assign bus.binv_vec   = binv_vec_q;

endmodule

// File: tb/tb_sf_assoc.sv
// Self-checking bench for sf_assoc: directed scenarios with literal results,
// then random traffic compared against a line-list model of the filter.
module tb_sf_assoc;
  import sf_pkg::*;

  localparam int ADDR_W   = 48;
  localparam int OFFSET_W = 6;
  localparam int SET_W    = 7;
  localparam int WAYS     = 4;
  localparam int NUM_RN   = 4;
  localparam int SET_NUM  = 1 << SET_W;
  localparam int TAG_W    = ADDR_W - OFFSET_W - SET_W;
  localparam int SRC_W    = $clog2(NUM_RN);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sf_assoc_if #(.ADDR_W(ADDR_W), .NUM_RN(NUM_RN)) bus ();

  sf_assoc #(
    .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .SET_W(SET_W), .WAYS(WAYS), .NUM_RN(NUM_RN)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  typedef struct {
    bit                valid;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        st;
    logic [NUM_RN-1:0] vec;
  } line_t;
  typedef struct { bit hit; logic [1:0] st; logic [NUM_RN-1:0] vec; } rsp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [NUM_RN-1:0] vec; } binv_t;

  line_t       mdl  [SET_NUM][WAYS];
  int unsigned mptr [SET_NUM];
  rsp_t        rsp_q[$];
  binv_t       binv_q[$];

  function automatic int set_of(input logic [ADDR_W-1:0] a);
    return int'((a >> OFFSET_W) % SET_NUM);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (OFFSET_W + SET_W));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SET_NUM; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mdl[s][w].valid = 0;
    end
    rsp_q.delete();
    binv_q.delete();
  endtask

  task automatic model_apply(input logic [ADDR_W-1:0] a, input sf_op_e op,
                             input logic [SRC_W-1:0] src);
    int s = set_of(a);
    logic [TAG_W-1:0] t = tag_of(a);
    logic [NUM_RN-1:0] oh = NUM_RN'(1) << src;
    int hw = -1;
    int w;
    rsp_t r;
    binv_t b;
    for (int i = 0; i < WAYS; i++)
      if (mdl[s][i].valid && mdl[s][i].tag == t) hw = i;
    r.hit = (hw >= 0);
    r.st  = r.hit ? mdl[s][hw].st  : SF_I;
    r.vec = r.hit ? mdl[s][hw].vec : '0;
    rsp_q.push_back(r);
    if (op == LOOKUP) return;
    if (op == EVICT) begin
      if (hw >= 0) begin
        mdl[s][hw].vec = mdl[s][hw].vec & ~oh;
        if (mdl[s][hw].vec == '0) begin
          mdl[s][hw].valid = 0;
          mdl[s][hw].st    = SF_I;
        end
      end
      return;
    end
    w = hw;
    if (w < 0) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!mdl[s][i].valid) w = i;
      if (w < 0) begin
        w = int'(mptr[s]);
        mptr[s] = (mptr[s] + 1) % WAYS;
        b.addr = (ADDR_W'(mdl[s][w].tag) << (OFFSET_W + SET_W)) | (ADDR_W'(s) << OFFSET_W);
        b.vec  = mdl[s][w].vec;
        binv_q.push_back(b);
      end
      mdl[s][w].valid = 1;
      mdl[s][w].tag   = t;
      mdl[s][w].vec   = '0;
    end
    if (op == ALLOC_SHARED) begin
      mdl[s][w].vec = mdl[s][w].vec | oh;
      mdl[s][w].st  = ($countones(mdl[s][w].vec) == 1) ? SF_U : SF_S;
    end else begin
      mdl[s][w].vec = oh;
      mdl[s][w].st  = SF_U;
    end
  endtask

  // Compare process: every response and every binv transfer against the model
  rsp_t              mon_r;
  binv_t             mon_b;
  logic              prev_bv, prev_br;
  logic [ADDR_W-1:0] prev_ba;
  logic [NUM_RN-1:0] prev_bvec;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bv = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_spurious", bus.rsp_valid, 0);
        else begin
          mon_r = rsp_q.pop_front();
          check("rsp_hit",   bus.rsp_hit,   mon_r.hit);
          check("rsp_state", bus.rsp_state, mon_r.st);
          check("rsp_vec",   bus.rsp_vec,   mon_r.vec);
        end
      end
      if (prev_bv && !prev_br)
        check("binv_hold", {bus.binv_valid, bus.binv_addr, bus.binv_vec}, {1'b1, prev_ba, prev_bvec});
      if (bus.binv_valid && bus.binv_ready) begin
        if (binv_q.size() == 0) check("binv_spurious", bus.binv_valid, 0);
        else begin
          mon_b = binv_q.pop_front();
          check("binv_addr", bus.binv_addr, mon_b.addr);
          check("binv_vec",  bus.binv_vec,  mon_b.vec);
        end
      end
      if (bus.req_valid && bus.req_ready) model_apply(bus.req_addr, bus.req_op, bus.req_src);
      prev_bv   = bus.binv_valid;
      prev_br   = bus.binv_ready;
      prev_ba   = bus.binv_addr;
      prev_bvec = bus.binv_vec;
    end
  end

  task automatic send(input logic [ADDR_W-1:0] a, input sf_op_e op, input int src);
    bit ok = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_op    = op;
    bus.req_src   = SRC_W'(src);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic do_req(input string nm, input logic [ADDR_W-1:0] a, input sf_op_e op,
                        input int src, input bit e_hit, input logic [1:0] e_st,
                        input logic [NUM_RN-1:0] e_vec);
    int k = 0;
    bit got = 0;
    send(a, op, src);
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid) got = 1;
    end
    check({nm, "_seen"}, got, 1);
    if (got) begin
      check({nm, "_latency"}, k, 2);
      check({nm, "_hit"}, bus.rsp_hit, e_hit);
      check({nm, "_state"}, bus.rsp_state, e_st);
      check({nm, "_vec"}, bus.rsp_vec, e_vec);
    end
  endtask

  task automatic set_binv_ready(input logic v);
    @(posedge clk); #1;
    bus.binv_ready = v;
  endtask

  function automatic logic [ADDR_W-1:0] set0_addr(input int k);
    return ADDR_W'(k) << (OFFSET_W + SET_W);
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = (ADDR_W'($urandom_range(0, 7)) << (OFFSET_W + SET_W))
      | (ADDR_W'($urandom_range(0, 1)) << OFFSET_W)
      | ADDR_W'($urandom_range(0, 63));
    if ($urandom_range(0, 1) == 1) a[ADDR_W-1] = 1'b1;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit last_acc;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_op     = LOOKUP;
    bus.req_src    = '0;
    bus.binv_ready = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  bus.req_ready, 0);
    check("rst_rsp_valid",  bus.rsp_valid, 0);
    check("rst_rsp_fields", {bus.rsp_hit, bus.rsp_vec}, 0);
    check("rst_rsp_state",  bus.rsp_state, SF_I);
    check("rst_binv",       {bus.binv_valid, bus.binv_addr, bus.binv_vec}, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", bus.req_ready, 1);

    do_req("lookup_cold",  48'h1000, LOOKUP,       0, 0, SF_I, 4'b0000);
    do_req("alloc_s_src1", 48'h1000, ALLOC_SHARED, 1, 0, SF_I, 4'b0000);
    do_req("alloc_s_src2", 48'h1000, ALLOC_SHARED, 2, 1, SF_U, 4'b0010);
    do_req("lookup_shr",   48'h1000, LOOKUP,       0, 1, SF_S, 4'b0110);
    do_req("alloc_u_src3", 48'h1000, ALLOC_UNIQUE, 3, 1, SF_S, 4'b0110);
    do_req("lookup_uniq",  48'h1000, LOOKUP,       0, 1, SF_U, 4'b1000);
    do_req("evict_last",   48'h1000, EVICT,        3, 1, SF_U, 4'b1000);
    do_req("lookup_gone",  48'h1000, LOOKUP,       0, 0, SF_I, 4'b0000);

    // Fill set 0, then a fifth tag evicts way 0 into a blocked binv slot
    set_binv_ready(1'b0);
    for (int k = 1; k <= 4; k++)
      do_req("fill", set0_addr(k), ALLOC_SHARED, k - 1, 0, SF_I, 4'b0000);
    do_req("fifth", set0_addr(5), ALLOC_SHARED, 0, 0, SF_I, 4'b0000);
    check("fifth_binv_valid", bus.binv_valid, 1);
    check("fifth_binv_addr",  bus.binv_addr,  set0_addr(1));
    check("fifth_binv_vec",   bus.binv_vec,   4'b0001);

    // Sixth miss needs the occupied slot and stalls in S1
    send(set0_addr(6), ALLOC_SHARED, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_rsp_withheld", bus.rsp_valid, 0);
      check("stall_req_ready",    bus.req_ready, 0);
    end
    set_binv_ready(1'b1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1;
    end
    check("sixth_seen", got, 1);
    check("sixth_rsp", {bus.rsp_hit, bus.rsp_state, bus.rsp_vec}, {1'b0, SF_I, 4'b0000});
    check("sixth_binv_addr", bus.binv_addr, set0_addr(2));
    check("sixth_binv_vec",  bus.binv_vec,  4'b0010);

    // Reset while S1 is stalled drops both the request and the pending binv
    set_binv_ready(1'b0);
    do_req("seventh", set0_addr(7), ALLOC_SHARED, 2, 0, SF_I, 4'b0000);
    check("seventh_binv_addr", bus.binv_addr, set0_addr(3));
    send(set0_addr(8), ALLOC_SHARED, 3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_binv_valid", bus.binv_valid, 0);
    check("midrst_rsp_valid",  bus.rsp_valid,  0);
    check("midrst_req_ready",  bus.req_ready,  0);
    model_reset();
    set_binv_ready(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {bus.rsp_valid, bus.binv_valid}, 0);
    end
    do_req("post_rst_lookup", set0_addr(5), LOOKUP, 0, 0, SF_I, 4'b0000);

    // Random traffic against the model
    last_acc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (!bus.req_valid || last_acc) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_addr  = rand_addr();
        bus.req_op    = sf_op_e'($urandom_range(0, 3));
        bus.req_src   = SRC_W'($urandom_range(0, NUM_RN - 1));
      end
      bus.binv_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      last_acc = bus.req_valid && bus.req_ready;
    end
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.binv_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rsp_drained",  rsp_q.size(),  0);
    check("binv_drained", binv_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
